// File: rtl/bcd_arb_pkg.sv
// Package: bcd_arb_pkg
// Shared types and constants for the shared binary->BCD converter arbiter.
//   arb_state_e : arbiter FSM state encoding
//   BCD_NINE    : digit value used to saturate an out-of-range result
//   ADD3        : double-dabble digit correction
//   ADJ_MIN     : digit value at/above which the correction is applied
//   maxdec()    : largest decimal value representable in a given digit count
package bcd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } arb_state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] ADD3     = 4'd3;
  localparam logic [3:0] ADJ_MIN  = 4'd5;

  function automatic int maxdec(input int digits);
    int r;
    r = 1;
    for (int i = 0; i < digits; i++) r = r * 10;
    return r - 1;
  endfunction

endpackage

// File: rtl/bcd_dd_core.sv
// Module: bcd_dd_core
// Sequential shift-and-add-3 (double-dabble) binary->BCD converter.
// A start pulse loads the operand and clears the digit accumulator on the same
// edge; the following DATA_W cycles each adjust and shift once. done is high in
// the last shift cycle, so the result in bcd is final from the next cycle on and
// held until the next start.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   start      : load bin and begin a conversion
//   bin        : binary operand
//   done       : high during the final shift cycle
//   bcd        : low DIGITS digits of the result, digit 0 in [3:0]
module bcd_dd_core
  import bcd_arb_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  // One spare digit so the adjust/shift never drops a carry.
  localparam int AW = 4 * (DIGITS + 1);
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [AW-1:0]        acc;
  logic [AW-1:0]        adj;
  logic [DATA_W-1:0]    opr;
  logic [CW-1:0]        cnt;
  logic                 run;
  logic                 last;
  logic [AW+DATA_W-1:0] shifted;

  always_comb begin
    adj = acc;
    for (int d = 0; d <= DIGITS; d++) begin
      if (acc[4*d +: 4] >= ADJ_MIN) adj[4*d +: 4] = acc[4*d +: 4] + ADD3;
    end
  end

  assign shifted = {adj, opr} << 1;
  assign last    = (cnt == CW'(DATA_W - 1));
  assign done    = run & last;
  assign bcd     = acc[4*DIGITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      opr <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      acc <= '0;
      opr <= bin;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      {acc, opr} <= shifted;
      cnt        <= last ? '0 : cnt + CW'(1);
      if (last) run <= 1'b0;
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Module: bcd_conv_arbiter
// Round-robin arbiter sharing one bcd_dd_core among N_REQ requesters. One
// request is accepted in IDLE, converted, and the result held in DONE until the
// downstream takes it.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   req_valid/ready   : per-requester handshake, req_ready one-hot, IDLE only
//   req_bin           : operands, requester i at [i*DATA_W +: DATA_W]
//   rsp_valid/ready   : result handshake
//   rsp_id            : requester index of the result
//   rsp_bcd           : BCD result, digit 0 in [3:0]
//   rsp_ovf           : operand above 10^DIGITS-1 (saturating build only)
//   busy              : FSM not in IDLE
// Build option: define BCD_SAT_EN to saturate out-of-range results to all nines
// and report rsp_ovf; otherwise the low DIGITS digits are returned, rsp_ovf = 0.
//
// state | meaning
// IDLE  | offering a grant to the first valid requester at/after the pointer
// SHIFT | core converting the accepted operand
// DONE  | result presented, waiting for rsp_ready
module bcd_conv_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 10,
  parameter int DIGITS = 3,
  parameter int ID_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_bin,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [4*DIGITS-1:0]     rsp_bcd,
  output logic                    rsp_ovf,
  output logic                    busy
);

  arb_state_e            state, state_nxt;
  logic [ID_W-1:0]       ptr;
  logic [N_REQ-1:0]      gnt;
  logic [ID_W-1:0]       gnt_idx;
  logic                  accept;
  logic                  core_done;
  logic [4*DIGITS-1:0]   core_bcd;

  function automatic int wrap_idx(input int base, input int ofs);
    int s;
    s = base + ofs;
    if (s >= N_REQ) s = s - N_REQ;
    return s;
  endfunction

  // First valid requester scanning upward from the pointer, wrapping.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[wrap_idx(int'(ptr), i)]) begin
        gnt     = '0;
        gnt[wrap_idx(int'(ptr), i)] = 1'b1;
        gnt_idx = ID_W'(wrap_idx(int'(ptr), i));
      end
    end
  end

  // Gated by rst_n so no grant is offered while reset is held.
  assign req_ready = (state == IDLE && rst_n) ? gnt : '0;
  assign accept    = (state == IDLE) && (gnt != '0);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = SHIFT;
      SHIFT:   if (core_done) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      rsp_id <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_id <= gnt_idx;
        ptr    <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
      end
    end
  end

  bcd_dd_core #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .bin   (req_bin[int'(gnt_idx)*DATA_W +: DATA_W]),
    .done  (core_done),
    .bcd   (core_bcd)
  );

`ifdef BCD_SAT_EN
  logic [DATA_W-1:0] op_q;
  logic              ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      op_q <= '0;
    else if (accept) op_q <= req_bin[int'(gnt_idx)*DATA_W +: DATA_W];
  end

  assign ovf     = (int'(op_q) > maxdec(DIGITS));
  assign rsp_ovf = ovf;
  assign rsp_bcd = ovf ? {DIGITS{BCD_NINE}} : core_bcd;
`else
  assign rsp_ovf = 1'b0;
  assign rsp_bcd = core_bcd;
`endif

endmodule
